// File: rtl/song_player.sv
// song_player: song ROM sequencer with debounced start/stop, light decode and looping; PLAYER_PAUSE_EN adds a PAUSED state
module song_player #(
  parameter int ADDR_W = 8,
  parameter int CMD_W = 12,
  parameter int NUM_LIGHTS = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  BTN_N,
  input  logic                  LOOP,
  output logic [ADDR_W-1:0]     ROM_ADDR,
  input  logic [CMD_W-1:0]      ROM_DATA,
  output logic [CMD_W-1:0]      CMD,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [NUM_LIGHTS-1:0] LIGHT_N,
  output logic                  PLAYING
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int IW = NUM_LIGHTS > 1 ? $clog2(NUM_LIGHTS) : 1;
  localparam logic [NUM_LIGHTS-1:0] DARK = '1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, ISSUE
`ifdef PLAYER_PAUSE_EN
    , PAUSED
`endif
  } state_t;

`ifdef PLAYER_PAUSE_EN
  localparam state_t HALT = PAUSED;
`else
  localparam state_t HALT = IDLE;
`endif

  logic btn_s1, btn_s2, btn_db, btn_db_q, press;
  logic [CW-1:0] cnt;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [CMD_W-1:0] word, word_n, cmd_n;
  logic valid_n, stop_pending, stop_n, stop;
  logic [NUM_LIGHTS-1:0] light_n, lit, decode;
  logic [1:0] sel;
  logic [IW-1:0] idx;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_db <= 1'b1;
      btn_db_q <= 1'b1;
      cnt <= '0;
    end else begin
      btn_s1 <= BTN_N;
      btn_s2 <= btn_s1;
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt <= '0;
        btn_db <= btn_s2;
      end else cnt <= cnt + CW'(1);
    end

  assign press = btn_db_q & ~btn_db;
  assign PLAYING = state != IDLE;

  // light decode is taken from the command being accepted
  always_comb begin
    sel = CMD[CMD_W-1 -: 2];
    idx = CMD[IW-1:0];
    lit = (32'(idx) < NUM_LIGHTS) ? ~(NUM_LIGHTS'(1) << idx) : DARK;
    decode = sel == 2'b01 ? lit : sel == 2'b00 ? DARK : LIGHT_N;
  end

  always_comb begin
    state_n = state;
    addr_n = ROM_ADDR;
    cmd_n = CMD;
    valid_n = CMD_VALID;
    light_n = LIGHT_N;
    word_n = word;
    stop = stop_pending | press;
    stop_n = stop_pending | (press & (state != IDLE) & (state != HALT));
    case (state)
      IDLE: if (press) begin
        addr_n = '0;
        state_n = FETCH;
      end
      FETCH: state_n = stop ? HALT : WAIT;
      WAIT: begin
        word_n = ROM_DATA;
        state_n = stop ? HALT : DECODE;
      end
      DECODE:
        if (stop) state_n = HALT;
        else if (&word) begin
          addr_n = LOOP ? '0 : ROM_ADDR;
          state_n = LOOP ? FETCH : IDLE;
        end else begin
          cmd_n = word;
          valid_n = 1'b1;
          state_n = ISSUE;
        end
      ISSUE: if (CMD_READY) begin
        valid_n = 1'b0;
        addr_n = ROM_ADDR + ADDR_W'(1);
        light_n = decode;
        state_n = (&ROM_ADDR && !LOOP) ? IDLE : FETCH;
      end
`ifdef PLAYER_PAUSE_EN
      PAUSED: state_n = press ? FETCH : PAUSED;
`endif
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) light_n = DARK;
    if (state_n == IDLE || state_n == HALT) stop_n = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      ROM_ADDR <= '0;
      CMD <= '0;
      CMD_VALID <= 1'b0;
      LIGHT_N <= DARK;
      stop_pending <= 1'b0;
      word <= '0;
    end else begin
      state <= state_n;
      ROM_ADDR <= addr_n;
      CMD <= cmd_n;
      CMD_VALID <= valid_n;
      LIGHT_N <= light_n;
      stop_pending <= stop_n;
      word <= word_n;
    end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: scoreboarded bench for song_player (pause sequence runs when PLAYER_PAUSE_EN is defined)
module tb_song_player;
  localparam int AW = 2, CW = 12, NL = 4, DB = 4;

  logic CLK = 1'b0, RST_N = 1'b0, BTN_N = 1'b1, LOOP = 1'b0, CMD_READY = 1'b0;
  logic [AW-1:0] ROM_ADDR;
  logic [CW-1:0] ROM_DATA, CMD;
  logic CMD_VALID, PLAYING;
  logic [NL-1:0] LIGHT_N;
  logic [CW-1:0] rom [4];
  int total = 0, bad = 0;

  typedef struct { logic [CW-1:0] cmd; logic [NL-1:0] light; } exp_t;
  typedef struct { logic [CW-1:0] w0, w1; logic [NL-1:0] l0, l1; } vec_t;
  exp_t exp_q[$];
  vec_t vt[5];

  song_player #(.ADDR_W(AW), .CMD_W(CW), .NUM_LIGHTS(NL), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_N(BTN_N), .LOOP(LOOP),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .CMD(CMD), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .LIGHT_N(LIGHT_N), .PLAYING(PLAYING)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic lchk = 1'b0, stall = 1'b0;
  logic [NL-1:0] lexp;
  logic [CW-1:0] scmd;
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      lchk = 1'b0;
      stall = 1'b0;
    end else begin
      if (lchk) chk("light", 32'(LIGHT_N), 32'(lexp));
      lchk = 1'b0;
      if (stall) begin
        chk("hold valid", 32'(CMD_VALID), 1);
        chk("hold cmd", 32'(CMD), 32'(scmd));
      end
      stall = CMD_VALID && !CMD_READY;
      scmd = CMD;
      if (CMD_VALID && CMD_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected cmd: got %0h want none", CMD);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", 32'(CMD), 32'(e.cmd));
          lchk = 1'b1;
          lexp = e.light;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(int low = 6);
    BTN_N = 1'b0;
    tick(low);
    BTN_N = 1'b1;
    tick(8);
  endtask

  task automatic push(logic [CW-1:0] c, logic [NL-1:0] l);
    exp_t e;
    e.cmd = c;
    e.light = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (PLAYING && n < 200) begin tick(); n++; end
    chk(name, 32'(PLAYING), 0);
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!CMD_VALID && n < 50) begin tick(); n++; end
    chk(name, 32'(CMD_VALID), 1);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic accept_one(string name);
    wait_valid(name);
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
  endtask

  initial begin
    vt[0] = '{12'h402, 12'h8FF, 4'b1011, 4'b1011};
    vt[1] = '{12'h403, 12'h000, 4'b0111, 4'b1111};
    vt[2] = '{12'h401, 12'h404, 4'b1101, 4'b1110};
    vt[3] = '{12'h400, 12'hC05, 4'b1110, 4'b1110};
    vt[4] = '{12'h8FF, 12'h7FE, 4'b1111, 4'b1011};
    rom = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

    tick(2);
    chk("rst valid", 32'(CMD_VALID), 0);
    chk("rst light", 32'(LIGHT_N), 32'hF);
    chk("rst playing", 32'(PLAYING), 0);
    chk("rst addr", 32'(ROM_ADDR), 0);
    chk("rst cmd", 32'(CMD), 0);
    RST_N = 1'b1;
    tick(2);

    BTN_N = 1'b0;
    tick(3);
    BTN_N = 1'b1;
    tick(10);
    chk("short press ignored", 32'(PLAYING), 0);

    rom = '{12'h402, 12'h401, 12'hFFF, 12'hFFF};
    push(12'h402, 4'b1011);
    press();
    chk("start playing", 32'(PLAYING), 1);
    chk("start addr", 32'(ROM_ADDR), 0);
    chk("start cmd", 32'(CMD), 32'h402);
    accept_one("first accept");
    wait_valid("second issue");
    #2 RST_N = 1'b0;
    #1;
    chk("async rst valid", 32'(CMD_VALID), 0);
    chk("async rst light", 32'(LIGHT_N), 32'hF);
    chk("async rst playing", 32'(PLAYING), 0);
    tick(2);
    RST_N = 1'b1;
    chk("async rst queue", exp_q.size(), 0);
    tick(2);

    rom = '{12'h401, 12'hFFF, 12'hFFF, 12'hFFF};
    CMD_READY = 1'b1;
    push(12'h401, 4'b1101);
    BTN_N = 1'b0;
    tick(30);
    BTN_N = 1'b1;
    tick(8);
    wait_idle("hold idle");
    wait_drain("hold drain");

    rom = '{12'h401, 12'h123, 12'h000, 12'hFFF};
    CMD_READY = 1'b0;
    push(12'h401, 4'b1101);
    push(12'h123, 4'b1111);
    push(12'h000, 4'b1111);
    press();
    wait_valid("stall issue");
    tick(5);
    chk("stall cmd", 32'(CMD), 32'h401);
    CMD_READY = 1'b1;
    wait_idle("play idle");
    wait_drain("play drain");
    tick(6);
    chk("end marker not issued", 32'(CMD_VALID), 0);

    LOOP = 1'b1;
    push(12'h401, 4'b1101);
    push(12'h123, 4'b1111);
    push(12'h000, 4'b1111);
    push(12'h401, 4'b1101);
    press();
    wait_drain("loop drain");
    CMD_READY = 1'b0;
    chk("loop playing", 32'(PLAYING), 1);
    push(12'h123, 4'b1111);
    wait_valid("loop stall");
    press();
    CMD_READY = 1'b1;
    wait_idle("stop idle");
    wait_drain("stop drain");
    tick(6);
    chk("stop no valid", 32'(CMD_VALID), 0);
    chk("stop light", 32'(LIGHT_N), 32'hF);
    LOOP = 1'b0;

    rom = '{12'h101, 12'h402, 12'h403, 12'h8AA};
    push(12'h101, 4'b1111);
    push(12'h402, 4'b1011);
    push(12'h403, 4'b0111);
    push(12'h8AA, 4'b1111);
    press();
    wait_idle("wrap idle");
    wait_drain("wrap drain");
    chk("wrap addr", 32'(ROM_ADDR), 0);
    chk("wrap light", 32'(LIGHT_N), 32'hF);

    foreach (vt[i]) begin
      rom = '{vt[i].w0, vt[i].w1, 12'hFFF, 12'hFFF};
      push(vt[i].w0, vt[i].l0);
      push(vt[i].w1, vt[i].l1);
      press();
      wait_idle("vec idle");
      wait_drain("vec drain");
    end

`ifdef PLAYER_PAUSE_EN
    rom = '{12'h401, 12'h123, 12'h402, 12'h403};
    CMD_READY = 1'b0;
    push(12'h401, 4'b1101);
    push(12'h123, 4'b1111);
    push(12'h402, 4'b1011);
    press();
    accept_one("pause a0");
    accept_one("pause a1");
    wait_valid("pause a2");
    chk("pause a2 cmd", 32'(CMD), 32'h402);
    press();
    accept_one("pause a2 accept");
    tick(4);
    chk("paused playing", 32'(PLAYING), 1);
    chk("paused addr", 32'(ROM_ADDR), 3);
    chk("paused light", 32'(LIGHT_N), 32'b1011);
    chk("paused valid", 32'(CMD_VALID), 0);
    push(12'h403, 4'b1111);
    press();
    accept_one("resume a3");
    wait_idle("resume idle");
    wait_drain("resume drain");
    chk("resume addr", 32'(ROM_ADDR), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
